// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx                                                         |
// | Purpose  : 8N1/8P1/8N2/8P2 UART transmitter with internal baud divider     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx #(
   parameter int CLK_DIV    = 5208,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       busy,
   output logic       Tx
);

   localparam int                  c_baud_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLK_DIV - 1);
   localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
   localparam logic [3:0]          c_data_last = 4'd7;
   localparam logic [3:0]          c_stop_last = 4'(STOP_BITS - 1);
   localparam logic                c_par_en    = (PARITY_EN != 0);
   localparam logic                c_par_odd   = (PARITY_ODD != 0);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_start  = 3'd1;
   localparam logic [2:0] c_st_data   = 3'd2;
   localparam logic [2:0] c_st_parity = 3'd3;
   localparam logic [2:0] c_st_stop   = 3'd4;

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic [c_baud_w-1:0] r_baud_cnt;
   logic [3:0]          r_bit_cnt;
   logic [7:0]          r_shift;
   logic                r_parity;
   logic                r_tx;
   logic                r_ready;
   logic                r_done;
   logic                w_accept;
   logic                w_bit_end;
   logic                w_state_chg;
   logic                w_tx_nxt;
   logic                w_ready_nxt;
   logic                w_done_nxt;

   // r_ready is only ever high in IDLE, so it doubles as the idle qualifier
   assign w_accept    = tx_valid & r_ready;
   assign w_bit_end   = (r_baud_cnt == c_baud_last);
   assign w_state_chg = (w_state_nxt != r_state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_tx    <= 1'b1;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
         r_ready <= w_ready_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:   if (w_accept)  w_state_nxt = c_st_start;
         c_st_start:  if (w_bit_end) w_state_nxt = c_st_data;
         c_st_data: begin
            if (w_bit_end && (r_bit_cnt == c_data_last))
               w_state_nxt = c_par_en ? c_st_parity : c_st_stop;
         end
         c_st_parity: if (w_bit_end) w_state_nxt = c_st_stop;
         c_st_stop: begin
            if (w_bit_end && (r_bit_cnt == c_stop_last))
               w_state_nxt = c_st_idle;
         end
         default:     w_state_nxt = c_st_idle;
      endcase
   end

   // Next values of the registered outputs; Tx changes only on bit boundaries
   always_comb begin
      w_tx_nxt    = r_tx;
      w_ready_nxt = r_ready;
      w_done_nxt  = 1'b0;
      case (r_state)
         c_st_idle: begin
            w_tx_nxt    = ~w_accept;
            w_ready_nxt = ~w_accept;
         end
         c_st_start: if (w_bit_end) w_tx_nxt = r_shift[0];
         c_st_data: begin
            if (w_bit_end) begin
               if (r_bit_cnt == c_data_last)
                  w_tx_nxt = c_par_en ? r_parity : 1'b1;
               else
                  w_tx_nxt = r_shift[1];
            end
         end
         c_st_parity: if (w_bit_end) w_tx_nxt = 1'b1;
         c_st_stop: begin
            if (w_bit_end && (r_bit_cnt == c_stop_last)) begin
               w_tx_nxt    = 1'b1;
               w_ready_nxt = 1'b1;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_tx_nxt    = 1'b1;
            w_ready_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (w_state_chg || (r_state == c_st_idle)) begin
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (w_bit_end) begin
         r_baud_cnt <= '0;
         r_bit_cnt  <= r_bit_cnt + 4'd1;
      end else begin
         r_baud_cnt <= r_baud_cnt + c_baud_one;
      end
   end

   // Parity is captured at accept because the shift register drains during DATA
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift  <= '0;
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_shift  <= tx_data;
         r_parity <= (^tx_data) ^ c_par_odd;
      end else if ((r_state == c_st_data) && w_bit_end) begin
         r_shift  <= {1'b0, r_shift[7:1]};
      end
   end

   assign Tx       = r_tx;
   assign tx_ready = r_ready;
   assign busy     = ~r_ready;
   assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx                                                      |
// | Purpose  : directed scoreboard bench for uart_tx in four configurations    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_tx;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [7:0] a_data, e_data, o_data, d_data;
   logic       a_valid, e_valid, o_valid, d_valid;
   logic       a_ready, e_ready, o_ready, d_ready;
   logic       a_done, e_done, o_done, d_done;
   logic       a_busy, e_busy, o_busy, d_busy;
   logic       a_tx, e_tx, o_tx, d_tx;

   uart_tx #(.CLK_DIV(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
      .tx_ready(a_ready), .tx_done(a_done), .busy(a_busy), .Tx(a_tx));
   uart_tx #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e (
      .clk(clk), .rst_n(rst_n), .tx_data(e_data), .tx_valid(e_valid),
      .tx_ready(e_ready), .tx_done(e_done), .busy(e_busy), .Tx(e_tx));
   uart_tx #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o (
      .clk(clk), .rst_n(rst_n), .tx_data(o_data), .tx_valid(o_valid),
      .tx_ready(o_ready), .tx_done(o_done), .busy(o_busy), .Tx(o_tx));
   uart_tx dut_d (
      .clk(clk), .rst_n(rst_n), .tx_data(d_data), .tx_valid(d_valid),
      .tx_ready(d_ready), .tx_done(d_done), .busy(d_busy), .Tx(d_tx));

   int   sel = 0;
   logic cur_tx, cur_ready, cur_busy, cur_done;
   always_comb begin
      cur_tx = a_tx; cur_ready = a_ready; cur_busy = a_busy; cur_done = a_done;
      case (sel)
         1: begin cur_tx = e_tx; cur_ready = e_ready; cur_busy = e_busy; cur_done = e_done; end
         2: begin cur_tx = o_tx; cur_ready = o_ready; cur_busy = o_busy; cur_done = o_done; end
         3: begin cur_tx = d_tx; cur_ready = d_ready; cur_busy = d_busy; cur_done = d_done; end
         default: ;
      endcase
   end

   int errors = 0;
   int checks = 0;
   int a_done_total = 0;
   logic expq[$];

   always @(posedge clk) if (a_done === 1'b1) a_done_total++;

   initial begin
      #1500000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] b, input int pen, input int podd, input int stops);
      logic p;
      p = (podd != 0);
      expq.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         expq.push_back(b[i]);
         p = p ^ b[i];
      end
      if (pen != 0) expq.push_back(p);
      for (int i = 0; i < stops; i++) expq.push_back(1'b1);
   endtask

   task automatic launch(input int s, input logic [7:0] b, input bit keep);
      @(negedge clk);
      case (s)
         0: begin a_data = b; a_valid = 1'b1; end
         1: begin e_data = b; e_valid = 1'b1; end
         2: begin o_data = b; o_valid = 1'b1; end
         default: begin d_data = b; d_valid = 1'b1; end
      endcase
      @(posedge clk);
      if (!keep) begin
         #1;
         a_valid = 1'b0; e_valid = 1'b0; o_valid = 1'b0; d_valid = 1'b0;
      end
   endtask

   // Called right after the accept edge; k counts edges since that edge
   task automatic observe(input string tag, input int nbits, input int d,
                          input logic [7:0] sent, input bit runs, output int last_k);
      int   early_done, busy_bad, prev_k;
      logic prev, exp_bit;
      logic [7:0] rx;
      early_done = 0; busy_bad = 0; prev_k = 0; last_k = 0; rx = 8'h00; prev = 1'b0;
      for (int k = 0; k <= nbits * d; k++) begin
         if (k > 0) @(posedge clk);
         @(negedge clk);
         if (k == 0) begin
            chk({tag, "_start_tx"}, cur_tx, 1'b0);
            chk({tag, "_start_ready"}, cur_ready, 1'b0);
            chk({tag, "_start_done"}, cur_done, 1'b0);
            prev = cur_tx;
         end else if (cur_tx !== prev) begin
            if (runs) chk($sformatf("%s_run_%0d", tag, k / d), k - prev_k, d);
            prev_k = k;
            last_k = k;
            prev   = cur_tx;
         end
         if (k < nbits * d) begin
            if (cur_done !== 1'b0) early_done++;
            if (cur_ready !== 1'b0 || cur_busy !== 1'b1) busy_bad++;
            if (k % d == d / 2) begin
               exp_bit = (expq.size() > 0) ? expq.pop_front() : 1'bx;
               chk($sformatf("%s_bit%0d", tag, k / d), cur_tx, exp_bit);
               if (k / d >= 1 && k / d <= 8) rx[k / d - 1] = cur_tx;
            end
         end
      end
      chk({tag, "_end_done"}, cur_done, 1'b1);
      chk({tag, "_end_ready"}, cur_ready, 1'b1);
      chk({tag, "_end_tx"}, cur_tx, 1'b1);
      chk({tag, "_early_done"}, early_done, 0);
      chk({tag, "_busy_window"}, busy_bad, 0);
      chk({tag, "_loopback"}, rx, sent);
   endtask

   initial begin
      int idle_bad, done_before, lk;
      rst_n = 1'b0;
      a_valid = 1'b0; e_valid = 1'b0; o_valid = 1'b0; d_valid = 1'b0;
      a_data = 8'h00; e_data = 8'h00; o_data = 8'h00; d_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx", a_tx, 1'b1);
      chk("rst_ready", a_ready, 1'b1);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_done", a_done, 1'b0);
      rst_n = 1'b1;

      idle_bad = 0;
      done_before = a_done_total;
      repeat (100) begin
         @(negedge clk);
         if (a_tx !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) idle_bad++;
      end
      chk("idle_levels", idle_bad, 0);
      chk("idle_no_done", a_done_total - done_before, 0);

      sel = 0;
      push_frame(8'hA5, 0, 0, 1);
      launch(0, 8'hA5, 1'b0);
      observe("a5", 10, 4, 8'hA5, 1'b0, lk);
      @(posedge clk); @(negedge clk);
      chk("a5_done_single", a_done, 1'b0);

      push_frame(8'h00, 0, 0, 1);
      push_frame(8'hFF, 0, 0, 1);
      launch(0, 8'h00, 1'b1);
      #1 a_data = 8'hFF;
      observe("b2b0", 10, 4, 8'h00, 1'b0, lk);
      @(posedge clk);
      #1 a_data = 8'h12;
      observe("b2b1", 10, 4, 8'hFF, 1'b0, lk);
      a_valid = 1'b0;
      idle_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (a_tx !== 1'b1 || a_ready !== 1'b1) idle_bad++;
      end
      chk("b2b_no_extra", idle_bad, 0);

      sel = 1;
      push_frame(8'h07, 1, 0, 1);
      launch(1, 8'h07, 1'b0);
      observe("even", 11, 4, 8'h07, 1'b0, lk);
      sel = 2;
      push_frame(8'h07, 1, 1, 2);
      launch(2, 8'h07, 1'b0);
      observe("odd2", 12, 4, 8'h07, 1'b0, lk);
      chk("odd2_stop_high", 48 - lk, 8);

      sel = 0;
      push_frame(8'h3C, 0, 0, 1);
      launch(0, 8'h3C, 1'b0);
      repeat (18) @(posedge clk);
      @(negedge clk);
      chk("abort_d3", a_tx, 1'b1);
      chk("abort_busy_before", a_ready, 1'b0);
      done_before = a_done_total;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_tx", a_tx, 1'b1);
      chk("abort_ready", a_ready, 1'b1);
      chk("abort_busy", a_busy, 1'b0);
      expq.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("abort_no_done", a_done_total - done_before, 0);
      chk("abort_idle_tx", a_tx, 1'b1);
      push_frame(8'h81, 0, 0, 1);
      launch(0, 8'h81, 1'b0);
      observe("post81", 10, 4, 8'h81, 1'b0, lk);

      sel = 3;
      push_frame(8'h55, 0, 0, 1);
      launch(3, 8'h55, 1'b0);
      observe("dflt55", 10, 5208, 8'h55, 1'b1, lk);
      chk("dflt55_last_edge", lk, 9 * 5208);
      chk("queue_drained", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
